// File: rtl/posit_to_float.sv
`default_nettype none
// ============================================================================
//  Module      : posit_to_float
//  Description : Four-stage pipelined converter from posit<32,2> to
//                IEEE-754 binary32 with round-to-nearest-even. Accepts one
//                operand per cycle; start/done fixed-latency handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_to_float #(
    parameter int NBITS   = 32,
    parameter int ES      = 2,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] in,
    output logic [31:0]      result,
    output logic             nar,
    output logic             zero,
    output logic             done
);

    // Fraction bits that survive after sign, the shortest regime (2 bits)
    // and the exponent field.
    localparam int c_frac_w = NBITS - 3 - ES;   // 27 for posit<32,2>

    // ------------------------------------------------------------------------
    // Stage 0: input capture
    // ------------------------------------------------------------------------
    logic [NBITS-1:0]   w_in_clean;
    logic               w_start_clean;
    logic [NBITS-1:0]   r0_in;
    logic [LATENCY-1:0] r_vld;

    // Unknown input bits are captured as 0 so X never enters the pipeline.
    always_comb begin
        w_in_clean = '0;
        for (int i = 0; i < NBITS; i++) begin
            w_in_clean[i] = (in[i] === 1'b1);
        end
        w_start_clean = (start === 1'b1);
    end

    // Valid bits travel alongside the data; one bit per stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[LATENCY-2:0], w_start_clean};
        end
    end

    // Operand register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r0_in <= '0;
        end else begin
            r0_in <= w_in_clean;
        end
    end

    assign done = r_vld[LATENCY-1];

    // ------------------------------------------------------------------------
    // Stage 1: sign / regime / exponent / fraction extraction
    // ------------------------------------------------------------------------
    logic [NBITS-1:0]      w_mag;
    logic [4:0]            w_run;
    logic                  w_scan_stop;
    logic [NBITS-4:0]      w_rem;
    logic [ES-1:0]         w_e;
    logic [c_frac_w-1:0]   w_frac;
    logic signed [7:0]     w_run8;
    logic signed [7:0]     w_k;
    logic signed [7:0]     w_scale;
    logic                  w_nar;
    logic                  w_zero;

    logic                  r1_sign;
    logic signed [7:0]     r1_scale;
    logic [c_frac_w-1:0]   r1_frac;
    logic                  r1_nar;
    logic                  r1_zero;

    // Two's-complement magnitude. Only NaR keeps bit 31 set after negation,
    // which makes that bit a free NaR detector.
    assign w_mag  = r0_in[NBITS-1] ? (~r0_in + 1'b1) : r0_in;
    assign w_nar  = w_mag[NBITS-1];
    assign w_zero = (r0_in == '0);

    // Regime run length: count bits equal to bit 30 from the top down.
    always_comb begin
        w_run       = 5'd0;
        w_scan_stop = 1'b0;
        for (int i = NBITS-2; i >= 0; i--) begin
            if (!w_scan_stop) begin
                if (w_mag[i] == w_mag[NBITS-2]) begin
                    w_run = w_run + 5'd1;
                end else begin
                    w_scan_stop = 1'b1;
                end
            end
        end
    end

    // Bits below the terminator start at position 29-run; shifting
    // mag[28:0] by run-1 left-aligns them. Run is always >= 1, and a
    // 31-bit run shifts everything out, zero-filling e and fraction.
    assign w_rem  = w_mag[NBITS-4:0] << (w_run - 5'd1);
    assign w_e    = w_rem[NBITS-4 -: ES];
    assign w_frac = w_rem[c_frac_w-1:0];

    assign w_run8  = $signed({3'b000, w_run});
    assign w_k     = w_mag[NBITS-2] ? (w_run8 - 8'sd1) : (8'sd0 - w_run8);
    assign w_scale = (w_k <<< ES) + $signed({{(8-ES){1'b0}}, w_e});

    // Extraction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_sign  <= 1'b0;
            r1_scale <= '0;
            r1_frac  <= '0;
            r1_nar   <= 1'b0;
            r1_zero  <= 1'b0;
        end else begin
            r1_sign  <= r0_in[NBITS-1];
            r1_scale <= w_scale;
            r1_frac  <= w_frac;
            r1_nar   <= w_nar;
            r1_zero  <= w_zero;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: round to 23 mantissa bits and bias the exponent
    // ------------------------------------------------------------------------
    logic        w_guard;
    logic        w_sticky;
    logic        w_lsb;
    logic        w_round_up;
    logic [23:0] w_mant_sum;
    logic [8:0]  w_exp9;
    logic [7:0]  w_exp8;

    logic        r2_sign;
    logic [7:0]  r2_exp;
    logic [22:0] r2_mant;
    logic        r2_nar;
    logic        r2_zero;

    assign w_guard    = r1_frac[3];
    assign w_sticky   = |r1_frac[2:0];
    assign w_lsb      = r1_frac[4];
    assign w_round_up = w_guard & (w_sticky | w_lsb);
    assign w_mant_sum = {1'b0, r1_frac[26:4]} + {23'd0, w_round_up};

    // A mantissa carry leaves the low 23 bits at zero and bumps the exponent.
    assign w_exp9 = {r1_scale[7], r1_scale} + 9'd127 + {8'd0, w_mant_sum[23]};

    // Scale is bounded to +/-120, so bit 8 never sets for a legal posit;
    // clamp to the largest finite exponent rather than wrap.
    assign w_exp8 = w_exp9[8] ? 8'hFE : w_exp9[7:0];

    // Rounding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r2_sign <= 1'b0;
            r2_exp  <= '0;
            r2_mant <= '0;
            r2_nar  <= 1'b0;
            r2_zero <= 1'b0;
        end else begin
            r2_sign <= r1_sign;
            r2_exp  <= w_exp8;
            r2_mant <= w_mant_sum[22:0];
            r2_nar  <= r1_nar;
            r2_zero <= r1_zero;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: pack and output register
    // ------------------------------------------------------------------------
    // Specials override the packed value; flags are qualified by valid so
    // they read 0 whenever done is low. result holds during bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= 32'h0000_0000;
            nar    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            nar  <= r_vld[2] & r2_nar;
            zero <= r_vld[2] & r2_zero & ~r2_nar;
            if (r_vld[2]) begin
                if (r2_nar) begin
                    result <= 32'h7FC0_0000;
                end else if (r2_zero) begin
                    result <= 32'h0000_0000;
                end else begin
                    result <= {r2_sign, r2_exp, r2_mant};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_posit_to_float.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_posit_to_float
//  Description : Self-checking bench for posit_to_float. A real-arithmetic
//                posit-to-float model predicts every done; a negedge
//                monitor checks timing, values and negation symmetry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_to_float;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pin;
    logic [31:0] result;
    logic        nar;
    logic        zero;
    logic        done;

    posit_to_float #(.NBITS(32), .ES(2), .LATENCY(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (pin),
        .result (result),
        .nar    (nar),
        .zero   (zero),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] p;
        int          due;
        logic [33:0] exp;     // {nar, zero, result}
        bit          pair_second;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] prev_res = 32'h0;

    // Posit<32,2> decoded to a real value, then rounded to binary32 (RNE).
    function automatic logic [33:0] model(input logic [31:0] p);
        logic [31:0] m;
        bit          s;
        bit          first;
        int          idx, run, k, e, sc, ex, fl;
        real         f, w, v, mant, rem;
        logic [7:0]  be;
        if (p == 32'h0) return {2'b01, 32'h0};
        if (p == 32'h8000_0000) return {2'b10, 32'h7FC0_0000};
        s = p[31];
        m = s ? (~p + 32'd1) : p;
        first = m[30];
        run = 0;
        idx = 30;
        while (idx >= 0 && m[idx] == first) begin
            run++;
            idx--;
        end
        idx--;
        k = first ? run - 1 : -run;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = e * 2 + ((idx >= 0) ? int'(m[idx]) : 0);
            idx--;
        end
        f = 0.0;
        w = 0.5;
        while (idx >= 0) begin
            if (m[idx]) f = f + w;
            w = w / 2.0;
            idx--;
        end
        sc = 4 * k + e;
        v = 1.0 + f;
        for (int j = 0; j < sc; j++) v = v * 2.0;
        for (int j = 0; j < -sc; j++) v = v / 2.0;
        ex = 0;
        while (v >= 2.0) begin v = v / 2.0; ex++; end
        while (v < 1.0)  begin v = v * 2.0; ex--; end
        mant = (v - 1.0) * 8388608.0;
        fl = $rtoi(mant);
        rem = mant - fl;
        if (rem > 0.5 || (rem == 0.5 && (fl % 2) == 1)) fl++;
        if (fl == 8388608) begin
            fl = 0;
            ex++;
        end
        be = 8'(ex + 127);
        return {2'b00, s, be, fl[22:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic issue(input logic [31:0] p, input bit pair2);
        exp_t t;
        @(posedge clk);
        #1;
        start = 1'b1;
        pin   = p;
        t.p = p;
        t.due = cyc + 4;
        t.exp = model(p);
        t.pair_second = pair2;
        q.push_back(t);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            pin   = $urandom;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            check("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        #1;
    endtask

    // Compare process: every cycle, either the oldest operand is due and
    // must appear, or done must be low.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("done_on_time", 64'(done), 64'd1);
                if (done === 1'b1) begin
                    check($sformatf("convert_%h", e.p), 64'({nar, zero, result}), 64'(e.exp));
                    if (e.pair_second) begin
                        check($sformatf("neg_symmetry_%h", e.p), 64'(result),
                              64'({~prev_res[31], prev_res[30:0]}));
                    end
                    prev_res = result;
                end
            end else begin
                check("done_idle", 64'(done), 64'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    logic [31:0] lit_in  [12];
    logic [33:0] lit_exp [12];

    initial begin
        logic [31:0] p;
        logic [31:0] np;

        lit_in[0]  = 32'h4000_0000; lit_exp[0]  = {2'b00, 32'h3F80_0000};
        lit_in[1]  = 32'hC000_0000; lit_exp[1]  = {2'b00, 32'hBF80_0000};
        lit_in[2]  = 32'h4800_0000; lit_exp[2]  = {2'b00, 32'h4000_0000};
        lit_in[3]  = 32'h3800_0000; lit_exp[3]  = {2'b00, 32'h3F00_0000};
        lit_in[4]  = 32'h7FFF_FFFF; lit_exp[4]  = {2'b00, 32'h7B80_0000};
        lit_in[5]  = 32'h0000_0001; lit_exp[5]  = {2'b00, 32'h0380_0000};
        lit_in[6]  = 32'h8000_0000; lit_exp[6]  = {2'b10, 32'h7FC0_0000};
        lit_in[7]  = 32'h0000_0000; lit_exp[7]  = {2'b01, 32'h0000_0000};
        lit_in[8]  = 32'h4000_0008; lit_exp[8]  = {2'b00, 32'h3F80_0000};
        lit_in[9]  = 32'h4000_0018; lit_exp[9]  = {2'b00, 32'h3F80_0002};
        lit_in[10] = 32'h4000_0009; lit_exp[10] = {2'b00, 32'h3F80_0001};
        lit_in[11] = 32'h47FF_FFF8; lit_exp[11] = {2'b00, 32'h4000_0000};

        reset = 1'b1;
        start = 1'b0;
        pin   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        check("reset_result", 64'(result), 64'd0);
        check("reset_nar",    64'(nar),    64'd0);
        check("reset_zero",   64'(zero),   64'd0);
        check("reset_done",   64'(done),   64'd0);

        // Pin the model to hand-computed values.
        for (int i = 0; i < 12; i++) begin
            check($sformatf("model_%h", lit_in[i]), 64'(model(lit_in[i])), 64'(lit_exp[i]));
        end

        // Directed values through the DUT, one start at a time.
        for (int i = 0; i < 12; i++) begin
            issue(lit_in[i], 1'b0);
            idle(6);
        end
        drain();

        // Throughput: 16 back-to-back, 3 idle, 2 more.
        for (int i = 0; i < 16; i++) issue($urandom, 1'b0);
        idle(3);
        for (int i = 0; i < 2; i++) issue($urandom, 1'b0);
        idle(1);
        drain();

        // Reset mid-stream discards in-flight operands.
        for (int i = 0; i < 3; i++) issue($urandom | 32'h1, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        issue(32'h4000_0000, 1'b0);
        idle(1);
        drain();

        // Random sweep: each sample followed by its negation.
        for (int i = 0; i < 3000; i++) begin
            p  = $urandom;
            np = ~p + 32'd1;
            issue(p, 1'b0);
            if (p != 32'h0 && p != 32'h8000_0000) issue(np, 1'b1);
        end
        idle(1);
        drain();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
